light_display_scan: RTL

LIGHT_DISPLAY_SCAN -- requirements
Module: light_display_scan

---
 rtl/light_display_scan_pkg.sv | 12 +
 rtl/light_display_scan_bcd_to_seg7.sv | 9 +
 rtl/light_display_scan.sv | 72 +++++++
 3 files changed

// File: rtl/light_display_scan_pkg.sv
// light_display_scan_pkg: segment patterns and digit-index constants shared by the display scanner
package light_display_scan_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6f, 7'h7f, 7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };
  localparam logic [1:0] IDX_A_L = 2'd0;
  localparam logic [1:0] IDX_A_H = 2'd1;
  localparam logic [1:0] IDX_B_L = 2'd2;
  localparam logic [1:0] IDX_B_H = 2'd3;
endpackage

// File: rtl/light_display_scan_bcd_to_seg7.sv
// bcd_to_seg7: nibble to {g..a} pattern; 0-9 digits, 10-14 blank, 15 dash
module bcd_to_seg7
  import light_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = (bcd <= 4'd9) ? SEG_DIGIT[bcd] : (bcd == 4'hf) ? SEG_DASH : SEG_BLANK;
endmodule

// File: rtl/light_display_scan.sv
// light_display_scan: 4-digit multiplexed countdown display with lamp drive and wink (flashing red) mode
module light_display_scan
  import light_display_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       A_Light,
  input  logic       B_Light,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       Wink,
  output logic [6:0] Seg,
  output logic [3:0] Dig_En,
  output logic       A_Green,
  output logic       A_Red,
  output logic       B_Green,
  output logic       B_Red
);
  logic [15:0] presc;
  logic [1:0] idx;
  logic [7:0] fcnt;
  logic phase;
  logic [3:0][3:0] snap;
  logic tick, frame_end, dark, blank_lz, conflict;
  logic [3:0] cur;
  logic [6:0] raw;
  assign tick = presc == 16'(SCAN_DIV - 1);
  assign frame_end = tick && idx == IDX_B_H;
  assign cur = snap[idx];
  // odd indices are the tens digits; a leading zero there is suppressed
  assign blank_lz = idx[0] && cur == 4'd0;
  assign dark = Wink && !phase;
  assign conflict = A_Light && B_Light;
  bcd_to_seg7 dec (.bcd(cur), .seg(raw));
  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc <= '0;
      idx <= IDX_A_L;
      fcnt <= '0;
      phase <= 1'b1;
      snap <= '1;
      Seg <= SEG_BLANK;
      Dig_En <= '0;
      A_Green <= 1'b0;
      B_Green <= 1'b0;
      A_Red <= 1'b1;
      B_Red <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 16'd1;
      if (tick) idx <= idx + 2'd1;
      if (frame_end) snap <= {B_Time_H, B_Time_L, A_Time_H, A_Time_L};
      if (!Wink) begin
        fcnt <= '0;
        phase <= 1'b1;
      end else if (frame_end) begin
        fcnt <= (fcnt == 8'(BLINK_DIV - 1)) ? '0 : fcnt + 8'd1;
        if (fcnt == 8'(BLINK_DIV - 1)) phase <= !phase;
      end
      Seg <= (dark || blank_lz) ? SEG_BLANK : raw;
      Dig_En <= dark ? 4'b0000 : 4'b0001 << idx;
      A_Green <= !Wink && A_Light && !conflict;
      B_Green <= !Wink && B_Light && !conflict;
      A_Red <= Wink ? phase : (!A_Light || conflict);
      B_Red <= Wink ? phase : (!B_Light || conflict);
    end
  end
endmodule
